// File: rtl/tail_light_seq_pkg.sv
// ---------------------------------------------------------------------------
// tail_light_seq_pkg
// Shared definitions for the tail-light sequencer:
//   - tl_state_e   : 4-bit state codes shown on the seven-segment display
//   - DEF_TICK_DIV : default prescaler ratio (clk cycles per sequence step)
//   - live_decode  : request inputs -> state code
//   - table_decode : raw playback table entry -> state code
// ---------------------------------------------------------------------------
package tail_light_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_R    = 4'd1,
        ST_L    = 4'd3,
        ST_B    = 4'd4,
        ST_BR   = 4'd5,
        ST_BL   = 4'd7,
        ST_HAZ  = 4'd8
    } tl_state_e;

    localparam int DEF_TICK_DIV = 2_500_000;

    // Left and right together is treated as a hazard request.
    function automatic tl_state_e live_decode(input logic left,
                                              input logic right,
                                              input logic brake,
                                              input logic hazard);
        tl_state_e s;
        if (hazard || (left && right)) begin
            s = ST_HAZ;
        end else begin
            case ({brake, left, right})
                3'b001:  s = ST_R;
                3'b010:  s = ST_L;
                3'b100:  s = ST_B;
                3'b101:  s = ST_BR;
                3'b110:  s = ST_BL;
                default: s = ST_IDLE;
            endcase
        end
        return s;
    endfunction

    // Codes 2 and 6 are unused encodings and fold onto idle / brake;
    // anything with bit 3 set is treated as hazard.
    function automatic tl_state_e table_decode(input logic [3:0] code);
        tl_state_e s;
        if (code[3]) begin
            s = ST_HAZ;
        end else begin
            case (code[2:0])
                3'd1:    s = ST_R;
                3'd3:    s = ST_L;
                3'd4:    s = ST_B;
                3'd6:    s = ST_B;
                3'd5:    s = ST_BR;
                3'd7:    s = ST_BL;
                default: s = ST_IDLE;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// ---------------------------------------------------------------------------
// tl_tick_gen
// Prescaler producing one step pulse every TICK_DIV clk cycles.
// Ports:
//   clk    in  system clock
//   rst    in  synchronous active-high reset
//   step_o out one-cycle pulse, high in the cycle the counter has wrapped to 0
// ---------------------------------------------------------------------------
module tl_tick_gen
    import tail_light_seq_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic step_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          step_q;

    // step_q is registered alongside the wrap so it is high exactly while the
    // counter sits at 0 after a wrap, and low straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else if (cnt_q == CW'(TICK_DIV - 1)) begin
            cnt_q  <= '0;
            step_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + CW'(1);
            step_q <= 1'b0;
        end
    end

    assign step_o = step_q;

endmodule

// File: rtl/tail_light_seq.sv
// ---------------------------------------------------------------------------
// tail_light_seq
// Parametrised tail-light sequencer: LAMPS lamps per side, on-chip step
// prescaler, and a playback mode that steps through a programmable table.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   left/right/brake/hazard  live requests (already synchronised)
//   pb_en             1 = state taken from playback table
//   pb_wr/pb_addr/pb_data    table write port (either mode)
//   lamps_l, lamps_r  lamp drives, bit 0 innermost
//   state_code        active state code for the seven-segment display
//   step              one-cycle pulse per sequence step
// ---------------------------------------------------------------------------
module tail_light_seq
    import tail_light_seq_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int PB_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        left,
    input  logic                        right,
    input  logic                        brake,
    input  logic                        hazard,
    input  logic                        pb_en,
    input  logic                        pb_wr,
    input  logic [$clog2(PB_DEPTH)-1:0] pb_addr,
    input  logic [3:0]                  pb_data,
    output logic [LAMPS-1:0]            lamps_l,
    output logic [LAMPS-1:0]            lamps_r,
    output logic [3:0]                  state_code,
    output logic                        step
);

    localparam int AW = $clog2(PB_DEPTH);
    localparam int PW = $clog2(LAMPS + 1);

    logic             step_w;
    logic [3:0]       pb_table_q [PB_DEPTH];
    logic [AW-1:0]    pb_ptr_q;
    tl_state_e        state_code_q;
    tl_state_e        state_d;
    logic [PW-1:0]    phase_q;
    logic [PW-1:0]    phase_d;
    logic [LAMPS-1:0] sweep;
    logic [LAMPS-1:0] lamps_l_q;
    logic [LAMPS-1:0] lamps_r_q;
    logic [LAMPS-1:0] lamps_l_d;
    logic [LAMPS-1:0] lamps_r_d;

    tl_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .step_o (step_w)
    );

    // Sweep mask: lowest phase_q bits set, growing outward from lamp 0.
    generate
        for (genvar gi = 0; gi < LAMPS; gi++) begin : g_sweep
            assign sweep[gi] = (phase_q > PW'(gi));
        end
    endgenerate

    always_comb begin
        state_d = pb_en ? table_decode(pb_table_q[pb_ptr_q])
                        : live_decode(left, right, brake, hazard);

        // A state change restarts the sweep and takes priority over a step.
        phase_d = phase_q;
        if (state_d != state_code_q) begin
            phase_d = '0;
        end else if (step_w) begin
            phase_d = (phase_q == PW'(LAMPS)) ? '0 : phase_q + PW'(1);
        end
    end

    always_comb begin
        lamps_l_d = '0;
        lamps_r_d = '0;
        case (state_code_q)
            ST_R:    lamps_r_d = sweep;
            ST_L:    lamps_l_d = sweep;
            ST_B: begin
                lamps_l_d = '1;
                lamps_r_d = '1;
            end
            ST_BR: begin
                lamps_l_d = '1;
                lamps_r_d = sweep;
            end
            ST_BL: begin
                lamps_l_d = sweep;
                lamps_r_d = '1;
            end
            ST_HAZ: begin
                // Blink at half the step rate: on for odd phases.
                if (phase_q[0]) begin
                    lamps_l_d = '1;
                    lamps_r_d = '1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PB_DEPTH; i++) begin
                pb_table_q[i] <= '0;
            end
            pb_ptr_q     <= '0;
            state_code_q <= ST_IDLE;
            phase_q      <= '0;
            lamps_l_q    <= '0;
            lamps_r_q    <= '0;
        end else begin
            if (pb_wr) begin
                pb_table_q[pb_addr] <= pb_data;
            end
            // Holding the pointer at 0 while playback is off means every
            // re-enable starts from entry 0. PB_DEPTH is a power of two, so
            // the natural counter wrap is the table wrap.
            if (!pb_en) begin
                pb_ptr_q <= '0;
            end else if (step_w) begin
                pb_ptr_q <= pb_ptr_q + AW'(1);
            end
            state_code_q <= state_d;
            phase_q      <= phase_d;
            lamps_l_q    <= lamps_l_d;
            lamps_r_q    <= lamps_r_d;
        end
    end

    assign lamps_l    = lamps_l_q;
    assign lamps_r    = lamps_r_q;
    assign state_code = state_code_q;
    assign step       = step_w;

endmodule

// File: tb/tb_tail_light_seq.sv
// ---------------------------------------------------------------------------
// tb_tail_light_seq
// Directed bench for tail_light_seq (LAMPS=3, TICK_DIV=4, PB_DEPTH=4).
// A behavioural model predicts every output each cycle; directed literal
// checks pin the expected sweep, blink and playback sequences.
// ---------------------------------------------------------------------------
module tb_tail_light_seq;

    localparam int LAMPS = 3;
    localparam int TD    = 4;
    localparam int PBD   = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             left = 1'b0;
    logic             right = 1'b0;
    logic             brake = 1'b0;
    logic             hazard = 1'b0;
    logic             pb_en = 1'b0;
    logic             pb_wr = 1'b0;
    logic [AW-1:0]    pb_addr = '0;
    logic [3:0]       pb_data = '0;
    logic [LAMPS-1:0] lamps_l;
    logic [LAMPS-1:0] lamps_r;
    logic [3:0]       state_code;
    logic             step;

    always #5 clk = ~clk;

    tail_light_seq #(
        .LAMPS    (LAMPS),
        .TICK_DIV (TD),
        .PB_DEPTH (PBD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .left       (left),
        .right      (right),
        .brake      (brake),
        .hazard     (hazard),
        .pb_en      (pb_en),
        .pb_wr      (pb_wr),
        .pb_addr    (pb_addr),
        .pb_data    (pb_data),
        .lamps_l    (lamps_l),
        .lamps_r    (lamps_r),
        .state_code (state_code),
        .step       (step)
    );

    // ---------------- behavioural model ----------------
    int m_cycles;
    int m_code;
    int m_phase;
    int m_ptr;
    int m_tbl [PBD];
    int e_l;
    int e_r;
    int e_code;
    int e_step;
    bit model_valid = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    function automatic int live_code(input logic l, input logic r,
                                     input logic b, input logic h);
        int c;
        if (h || (l && r)) return 8;
        c = 0;
        if (r) c = 1;
        if (l) c = 3;
        if (b) c = c + 4;
        return c;
    endfunction

    function automatic int canon_code(input int c);
        if (c >= 8) return 8;
        if (c == 2 || c == 6) return c - 2;
        return c;
    endfunction

    task automatic lamp_rule(input int code, input int phase,
                             output int l, output int r);
        int all_on;
        int sw;
        bit turn_l;
        bit turn_r;
        bit brk;
        all_on = (1 << LAMPS) - 1;
        sw     = (1 << phase) - 1;
        if (code == 8) begin
            l = (phase % 2 == 1) ? all_on : 0;
            r = l;
        end else begin
            turn_r = (code % 4 == 1);
            turn_l = (code % 4 == 3);
            brk    = (code >= 4);
            l = turn_l ? sw : (brk ? all_on : 0);
            r = turn_r ? sw : (brk ? all_on : 0);
        end
    endtask

    // One rising edge of the model, using the inputs as they stand now.
    task automatic model_edge();
        int new_code;
        bit step_now;
        if (rst) begin
            m_cycles = 0;
            m_code   = 0;
            m_phase  = 0;
            m_ptr    = 0;
            for (int i = 0; i < PBD; i++) m_tbl[i] = 0;
            e_l = 0;
            e_r = 0;
            e_code = 0;
            e_step = 0;
            model_valid = 1'b1;
        end else begin
            step_now = (m_cycles != 0) && (m_cycles % TD == 0);
            lamp_rule(m_code, m_phase, e_l, e_r);
            new_code = pb_en ? canon_code(m_tbl[m_ptr])
                             : live_code(left, right, brake, hazard);
            if (new_code != m_code) m_phase = 0;
            else if (step_now) m_phase = (m_phase + 1) % (LAMPS + 1);
            m_code = new_code;
            if (!pb_en) m_ptr = 0;
            else if (step_now) m_ptr = (m_ptr + 1) % PBD;
            if (pb_wr) m_tbl[pb_addr] = int'(pb_data);
            m_cycles = m_cycles + 1;
            e_code = m_code;
            e_step = (m_cycles % TD == 0) ? 1 : 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Advance one clock: model follows the rising edge, outputs are
    // compared against the model at the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (model_valid) begin
            check("cyc_lamps_l", 32'(lamps_l), 32'(e_l));
            check("cyc_lamps_r", 32'(lamps_r), 32'(e_r));
            check("cyc_state", 32'(state_code), 32'(e_code));
            check("cyc_step", 32'(step), 32'(e_step));
        end
    endtask

    task automatic wait_step(output int n);
        bit found;
        found = 1'b0;
        n = 0;
        for (int i = 0; i < 3 * TD && !found; i++) begin
            cyc();
            n++;
            if (step === 1'b1) found = 1'b1;
        end
        if (!found) begin
            n_total++;
            $display("FAIL step_timeout: no step within %0d cycles", 3 * TD);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n;
    int sweep_exp [4] = '{1, 3, 7, 0};
    int pb_vals [4]   = '{1, 3, 8, 4};
    int pb_seq [5]    = '{1, 3, 8, 4, 1};

    initial begin
        // 1: reset held 3 clk with left asserted
        rst  = 1'b1;
        left = 1'b1;
        repeat (3) cyc();
        check("rst_lamps_l", 32'(lamps_l), 0);
        check("rst_lamps_r", 32'(lamps_r), 0);
        check("rst_state", 32'(state_code), 0);
        check("rst_step", 32'(step), 0);
        rst = 1'b0;
        wait_step(n);
        $display("first step after %0d cycles, state_code=%0d", n, state_code);
        check("first_step_latency", 32'(n), 4);
        check("t1_state_left", 32'(state_code), 3);
        check("t2_sweep0", 32'(lamps_l), 0);

        // 2: left steady sweeps outward, right side dark
        for (int k = 0; k < 4; k++) begin
            wait_step(n);
            $display("step: lamps_l=%b lamps_r=%b", lamps_l, lamps_r);
            check("step_period", 32'(n), 4);
            check("t2_sweep_l", 32'(lamps_l), 32'(sweep_exp[k]));
            check("t2_sweep_r", 32'(lamps_r), 0);
        end

        // 3: right + brake, then drop brake mid-sweep
        left  = 1'b0;
        right = 1'b1;
        brake = 1'b1;
        wait_step(n);
        check("t3_state_br", 32'(state_code), 5);
        check("t3_l_on", 32'(lamps_l), 7);
        check("t3_r0", 32'(lamps_r), 0);
        wait_step(n);
        check("t3_r1", 32'(lamps_r), 1);
        wait_step(n);
        check("t3_r3", 32'(lamps_r), 3);
        brake = 1'b0;
        cyc();
        check("t3_state_r", 32'(state_code), 1);
        cyc();
        check("t3_l_off", 32'(lamps_l), 0);
        check("t3_r_restart", 32'(lamps_r), 0);
        wait_step(n);
        check("t3_r_ph0", 32'(lamps_r), 0);
        wait_step(n);
        check("t3_r_ph1", 32'(lamps_r), 1);

        // 4: left+right acts as hazard; then hazard alone continues blinking
        left  = 1'b1;
        right = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_step(n);
            $display("hazard step: lamps_l=%b lamps_r=%b code=%0d", lamps_l, lamps_r, state_code);
            check("t4_state", 32'(state_code), 8);
            check("t4_blink_l", 32'(lamps_l), (k % 2 == 1) ? 7 : 0);
            check("t4_blink_r", 32'(lamps_r), (k % 2 == 1) ? 7 : 0);
        end
        left   = 1'b0;
        right  = 1'b0;
        hazard = 1'b1;
        wait_step(n);
        check("t4_haz_off", 32'(lamps_l), 0);
        check("t4_haz_state", 32'(state_code), 8);
        wait_step(n);
        check("t4_haz_on", 32'(lamps_r), 7);

        // 5: playback of {1,3,8,4}
        hazard = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pb_wr   = 1'b1;
            pb_addr = AW'(i);
            pb_data = 4'(pb_vals[i]);
            cyc();
        end
        pb_wr = 1'b0;
        wait_step(n);
        cyc();
        pb_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_step(n);
            $display("playback step: state_code=%0d", state_code);
            check("t5_pb_seq", 32'(state_code), 32'(pb_seq[k]));
        end
        cyc();
        pb_en = 1'b0;
        cyc();
        check("t5_pb_off", 32'(state_code), 0);
        pb_en = 1'b1;
        cyc();
        check("t5_pb_restart", 32'(state_code), 1);
        // unused encodings folded: 6 -> brake, 10 -> hazard
        pb_wr   = 1'b1;
        pb_addr = AW'(1);
        pb_data = 4'd6;
        cyc();
        pb_addr = AW'(2);
        pb_data = 4'd10;
        cyc();
        pb_wr = 1'b0;
        repeat (4) wait_step(n);

        // 6: reset mid-sweep, coincident with a step and a table write
        pb_en = 1'b0;
        left  = 1'b1;
        repeat (3) wait_step(n);
        rst     = 1'b1;
        pb_wr   = 1'b1;
        pb_addr = '0;
        pb_data = 4'd5;
        cyc();
        check("t6_rst_l", 32'(lamps_l), 0);
        check("t6_rst_state", 32'(state_code), 0);
        check("t6_rst_step", 32'(step), 0);
        rst   = 1'b0;
        pb_wr = 1'b0;
        left  = 1'b0;
        pb_en = 1'b1;
        cyc();
        cyc();
        check("t6_table_cleared", 32'(state_code), 0);
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
